// File: rtl/tx_ila_if.sv
// Lane-side bundle for the JESD204B transmit ILA generator: LMFC strobe,
// link configuration in, and the octet stream plus status out.
interface tx_ila_if;
  logic         lmfc_clk;
  logic [2:0]   i_link_mux;
  logic [7:0]   i_F;
  logic [4:0]   i_K;
  logic [7:0]   i_ila_multiframe_length;
  logic [111:0] i_config;
  logic [7:0]   o_data;
  logic         o_is_k;
  logic         o_ila_done;
  logic         o_cfg_err;

  modport master (
    output lmfc_clk, i_link_mux, i_F, i_K, i_ila_multiframe_length, i_config,
    input  o_data, o_is_k, o_ila_done, o_cfg_err
  );

  modport slave (
    input  lmfc_clk, i_link_mux, i_F, i_K, i_ila_multiframe_length, i_config,
    output o_data, o_is_k, o_ila_done, o_cfg_err
  );
endinterface

// File: rtl/tx_ila_gen.sv
// JESD204B transmit initial lane alignment sequence generator, one octet per clk.
// Starts on an LMFC boundary, emits N multiframes of L octets, then flags done.
module tx_ila_gen (
  input  logic      clk,
  input  logic      rst_n,
  tx_ila_if.slave   bus
);
  localparam logic [7:0] K_CHAR = 8'hBC;
  localparam logic [7:0] R_CHAR = 8'h1C;
  localparam logic [7:0] A_CHAR = 8'h7C;
  localparam logic [7:0] Q_CHAR = 8'h9C;

  typedef enum logic [1:0] {IDLE, WAIT_LMFC, SEND, DONE} state_e;

  state_e        state_q, state_d;
  logic [12:0]   oc_q, oc_d;
  logic [8:0]    mf_q, mf_d;
  logic [13:0]   len_l_q, len_l_d;
  logic [8:0]    len_n_q, len_n_d;
  logic [111:0]  cfg_q, cfg_d;
  logic [7:0]    data_q, data_d;
  logic          is_k_q, is_k_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          mux_ila, start, emit, last_oc, last_mf;
  logic [13:0]   l_live, cur_l;
  logic [8:0]    n_live, cur_n, cur_mf;
  logic [12:0]   cur_oc;
  logic [3:0]    cfg_idx;
  logic [127:0]  cfg_ext;

  assign mux_ila = (bus.i_link_mux == 3'd2);
  assign l_live  = (14'(bus.i_F) + 14'd1) * (14'(bus.i_K) + 14'd1);
  assign n_live  = 9'(bus.i_ila_multiframe_length) + 9'd1;
  assign start   = (state_q == WAIT_LMFC) && mux_ila && bus.lmfc_clk;
  assign emit    = start || ((state_q == SEND) && mux_ila);

  // The start cycle itself is octet (0,0), using the live configuration.
  assign cur_oc  = start ? 13'd0 : oc_q;
  assign cur_mf  = start ? 9'd0  : mf_q;
  assign cur_l   = start ? l_live : len_l_q;
  assign cur_n   = start ? n_live : len_n_q;
  assign last_oc = ({1'b0, cur_oc} == cur_l - 14'd1);
  assign last_mf = (cur_mf == cur_n - 9'd1);
  assign cfg_idx = cur_oc[3:0] - 4'd2;
  assign cfg_ext = {16'h0000, cfg_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      oc_q      <= '0;
      mf_q      <= '0;
      data_q    <= K_CHAR;
      is_k_q    <= 1'b1;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      oc_q      <= oc_d;
      mf_q      <= mf_d;
      data_q    <= data_d;
      is_k_q    <= is_k_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // NOTE: configuration latches are pure datapath, only read after being loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    len_l_q <= len_l_d;
    len_n_q <= len_n_d;
    cfg_q   <= cfg_d;
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    oc_d    = oc_q;
    mf_d    = mf_q;
    len_l_d = len_l_q;
    len_n_d = len_n_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      IDLE:      if (mux_ila && (l_live >= 14'd17)) state_d = WAIT_LMFC;
      WAIT_LMFC: if (!mux_ila) state_d = IDLE;
                 else if (bus.lmfc_clk) begin
                   len_l_d = l_live;
                   len_n_d = n_live;
                   cfg_d   = bus.i_config;
                 end
      SEND, DONE: if (!mux_ila) begin
                   state_d = IDLE;
                   oc_d    = '0;
                   mf_d    = '0;
                 end
      default:   state_d = IDLE;
    endcase
    if (emit) begin
      state_d = SEND;
      if (last_oc) begin
        oc_d = '0;
        if (last_mf) begin
          mf_d    = '0;
          state_d = DONE;
        end else begin
          mf_d = cur_mf + 9'd1;
        end
      end else begin
        oc_d = cur_oc + 13'd1;
        mf_d = cur_mf;
      end
    end
  end

  // Output octet selection, registered one cycle later.
  always_comb begin
    data_d    = K_CHAR;
    is_k_d    = 1'b1;
    done_d    = (state_q == DONE) && mux_ila;
    cfg_err_d = (state_q == IDLE) && mux_ila && (l_live < 14'd17);
    if (emit) begin
      if (cur_oc == 13'd0) begin
        data_d = R_CHAR;
      end else if (last_oc) begin
        data_d = A_CHAR;
      end else if ((cur_mf == 9'd1) && (cur_oc == 13'd1)) begin
        data_d = Q_CHAR;
      end else if ((cur_mf == 9'd1) && (cur_oc <= 13'd15)) begin
        data_d = cfg_ext[{cfg_idx, 3'b000} +: 8];
        is_k_d = 1'b0;
      end else begin
        data_d = cur_oc[7:0];
        is_k_d = 1'b0;
      end
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_is_k     = is_k_q;
  assign bus.o_ila_done = done_q;
  assign bus.o_cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_tx_ila_gen.sv
// Directed bench for tx_ila_gen: full ILA, config latching, abort, reset,
// configuration error and the minimum multiframe length.
module tb_tx_ila_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_ila_if ifc ();
  tx_ila_gen dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc_cnt  = 0;
  bit           lmfc_en  = 1'b0;
  logic [8:0]   cap [0:127];
  logic [111:0] cfg_ramp;
  logic [111:0] cfg_ones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; LMFC pulses every 32 cycles when enabled.
  task automatic cyc();
    @(negedge clk);
    cyc_cnt++;
    ifc.lmfc_clk = lmfc_en && (cyc_cnt % 32 == 0);
  endtask

  function automatic logic [8:0] obs_oct();
    return {ifc.o_is_k, ifc.o_data};
  endfunction

  function automatic logic [8:0] exp_oct(input int mf, input int oc, input int l,
                                         input logic [111:0] cfg);
    if (oc == 0)                        return {1'b1, 8'h1C};
    if (oc == l - 1)                    return {1'b1, 8'h7C};
    if (mf == 1 && oc == 1)             return {1'b1, 8'h9C};
    if (mf == 1 && oc >= 2 && oc <= 15) return {1'b0, cfg[8*(oc-2) +: 8]};
    return {1'b0, 8'(oc)};
  endfunction

  task automatic wait_r(input int bound, output bit found);
    int waited = 0;
    while (!(ifc.o_data == 8'h1C && ifc.o_is_k) && waited < bound) begin
      cyc();
      waited++;
    end
    found = (ifc.o_data == 8'h1C && ifc.o_is_k);
  endtask

  initial begin
    bit found;
    int t0;
    int r_seen;
    int bad;
    for (int i = 0; i < 14; i++) cfg_ramp[8*i +: 8] = 8'(i);
    cfg_ones = '1;
    ifc.lmfc_clk = 1'b0;
    ifc.i_link_mux = 3'd0;
    ifc.i_F = 8'd1;
    ifc.i_K = 5'd15;
    ifc.i_ila_multiframe_length = 8'd3;
    ifc.i_config = cfg_ramp;

    #12;
    check("rst_data", 32'(ifc.o_data), 32'hBC);
    check("rst_is_k", 32'(ifc.o_is_k), 32'd1);
    check("rst_done", 32'(ifc.o_ila_done), 32'd0);
    check("rst_cfg_err", 32'(ifc.o_cfg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lmfc_en = 1'b1;

    // Full ILA, L=32, N=4; mux rises together with an LMFC pulse.
    do cyc(); while (cyc_cnt % 32 != 0);
    ifc.i_link_mux = 3'd2;
    t0 = cyc_cnt;
    cyc();
    check("coincident_no_start", 32'(obs_oct()), {23'd0, 1'b1, 8'hBC});
    wait_r(100, found);
    check("t1_start_found", 32'(found), 32'd1);
    check("t1_start_latency", 32'(cyc_cnt - t0), 32'd33);
    cap[0] = obs_oct();
    ifc.i_config = cfg_ones;
    for (int i = 1; i < 128; i++) begin
      cyc();
      cap[i] = obs_oct();
    end
    check("t1_done_at_last_a", 32'(ifc.o_ila_done), 32'd0);
    cyc();
    check("t1_done_rise", 32'(ifc.o_ila_done), 32'd1);
    check("t1_done_data", 32'(obs_oct()), {23'd0, 1'b1, 8'hBC});
    for (int i = 0; i < 128; i++)
      check($sformatf("t1_mf%0d_oc%0d", i / 32, i % 32), 32'(cap[i]),
            32'(exp_oct(i / 32, i % 32, 32, cfg_ramp)));
    cyc();
    check("t1_done_hold", 32'(ifc.o_ila_done), 32'd1);

    // Leave DONE, then abort a fresh ILA at mf1 oc5.
    ifc.i_link_mux = 3'd0;
    cyc();
    check("done_clear", 32'(ifc.o_ila_done), 32'd0);
    ifc.i_link_mux = 3'd2;
    wait_r(100, found);
    check("t2_start_found", 32'(found), 32'd1);
    cap[0] = obs_oct();
    for (int i = 1; i <= 37; i++) begin
      cyc();
      cap[i] = obs_oct();
    end
    ifc.i_link_mux = 3'd0;
    cyc();
    check("abort_data", 32'(obs_oct()), {23'd0, 1'b1, 8'hBC});
    check("abort_done", 32'(ifc.o_ila_done), 32'd0);
    check("t2_mf1_r", 32'(cap[32]), {23'd0, 1'b1, 8'h1C});
    check("t2_mf1_q", 32'(cap[33]), {23'd0, 1'b1, 8'h9C});
    check("t2_cfg0_relatched", 32'(cap[34]), {23'd0, 1'b0, 8'hFF});
    check("t2_cfg3_relatched", 32'(cap[37]), {23'd0, 1'b0, 8'hFF});
    ifc.i_link_mux = 3'd2;
    wait_r(100, found);
    check("t3_restart_found", 32'(found), 32'd1);
    cyc();
    check("t3_mf0_oc1", 32'(obs_oct()), {23'd0, 1'b0, 8'h01});

    // Asynchronous reset in the middle of SEND.
    for (int i = 0; i < 5; i++) cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(ifc.o_data), 32'hBC);
    check("mid_rst_is_k", 32'(ifc.o_is_k), 32'd1);
    check("mid_rst_done", 32'(ifc.o_ila_done), 32'd0);
    check("mid_rst_cfg_err", 32'(ifc.o_cfg_err), 32'd0);
    ifc.i_link_mux = 3'd0;
    cyc();
    cyc();
    rst_n = 1'b1;
    r_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (ifc.o_data == 8'h1C) r_seen++;
    end
    check("post_rst_idle", 32'(r_seen), 32'd0);
    ifc.i_link_mux = 3'd2;
    wait_r(100, found);
    check("post_rst_start", 32'(found), 32'd1);

    // L = 16 is too short: error flag, no sequence.
    ifc.i_link_mux = 3'd0;
    cyc();
    ifc.i_F = 8'd0;
    ifc.i_K = 5'd15;
    ifc.i_link_mux = 3'd2;
    cyc();
    check("cfg_err_set", 32'(ifc.o_cfg_err), 32'd1);
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      if (obs_oct() != {1'b1, 8'hBC} || !ifc.o_cfg_err) bad++;
    end
    check("cfg_err_hold_k", 32'(bad), 32'd0);
    ifc.i_link_mux = 3'd0;
    cyc();
    check("cfg_err_clear", 32'(ifc.o_cfg_err), 32'd0);

    // Minimum legal length: L = 17, N = 1.
    ifc.i_K = 5'd16;
    ifc.i_ila_multiframe_length = 8'd0;
    ifc.i_link_mux = 3'd2;
    cyc();
    check("l17_no_cfg_err", 32'(ifc.o_cfg_err), 32'd0);
    wait_r(100, found);
    check("l17_start_found", 32'(found), 32'd1);
    cap[0] = obs_oct();
    for (int i = 1; i < 17; i++) begin
      cyc();
      cap[i] = obs_oct();
    end
    check("l17_oc1", 32'(cap[1]), {23'd0, 1'b0, 8'h01});
    check("l17_oc15", 32'(cap[15]), {23'd0, 1'b0, 8'h0F});
    check("l17_last_a", 32'(cap[16]), {23'd0, 1'b1, 8'h7C});
    cyc();
    check("l17_done", 32'(ifc.o_ila_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
